// File: rtl/dac_feeder_pkg.sv
// Shared types for the DAC sample feeder: frame word, midscale constant,
// byte-phase encoding and a frame packing helper.
package dac_feeder_pkg;

   typedef logic [15:0] frame_t;

   localparam frame_t MIDSCALE = 16'h8080;

   typedef enum logic {
      PH_LO,
      PH_HI
   } phase_t;

   // High byte drives the ua[0] DAC, low byte the ua[1] DAC.
   function automatic frame_t pack_frame(
      input logic [7:0] hi,
      input logic [7:0] lo
   );
      return {hi, lo};
   endfunction

endpackage

// File: rtl/dac_frame_fifo.sv
// Synchronous frame FIFO with first-word-fall-through head.
// Depth must be a power of two so the pointers wrap naturally.
module dac_frame_fifo
   import dac_feeder_pkg::*;
#(
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH),
   localparam int LW = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  frame_t        wr_data,
   input  logic          pop,
   output frame_t        head,
   output logic          full,
   output logic          empty,
   output logic [LW-1:0] level
);

   frame_t mem [DEPTH];

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         unique case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/dac_sample_feeder.sv
// Pairs pad bytes into stereo frames and releases one per sample period.
// Define DAC_FEEDER_MUTE_EN to output midscale on underrun instead of holding.
module dac_sample_feeder
   import dac_feeder_pkg::*;
#(
   parameter int CLK_DIV    = 1250,
   parameter int FIFO_DEPTH = 8,
   localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          run,
   input  logic [7:0]    in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [15:0]   sample,
   output logic          sample_stb,
   output logic          underrun,
   output logic [LW-1:0] fifo_level
);

   localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

   phase_t      phase;
   logic [7:0]  lo_hold;
   logic [15:0] div_cnt;
   logic        accept;
   logic        push;
   logic        boundary;
   frame_t      head;
   logic        full;
   logic        empty;

   assign in_ready = (phase == PH_LO) || !full;
   assign accept   = in_valid && in_ready;
   assign push     = accept && (phase == PH_HI);
   assign boundary = run && (div_cnt == DIV_LAST);

   dac_frame_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .wr_data (pack_frame(in_data, lo_hold)),
      .pop     (boundary),
      .head    (head),
      .full    (full),
      .empty   (empty),
      .level   (fifo_level)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         phase   <= PH_LO;
         lo_hold <= '0;
      end else if (accept) begin
         unique case (phase)
            PH_LO: begin
               lo_hold <= in_data;
               phase   <= PH_HI;
            end
            PH_HI: begin
               phase <= PH_LO;
            end
            default: phase <= PH_LO;
         endcase
      end
   end

   // Pausing parks the divider so a restart always yields a full period.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt <= '0;
      end else if (!run || boundary) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sample     <= MIDSCALE;
         sample_stb <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         sample_stb <= boundary;
         underrun   <= boundary && empty;
         if (boundary && !empty) begin
            sample <= head;
         end
`ifdef DAC_FEEDER_MUTE_EN
         else if (boundary) begin
            sample <= MIDSCALE;
         end
`endif
      end
   end

endmodule

// File: tb/tb_dac_sample_feeder.sv
// Randomized and directed bench for dac_sample_feeder against a
// queue-based reference model (CLK_DIV=4, FIFO_DEPTH=4).
module tb_dac_sample_feeder;

   localparam int CLK_DIV    = 4;
   localparam int FIFO_DEPTH = 4;
   localparam int LW         = $clog2(FIFO_DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          run;
   logic [7:0]    in_data;
   logic          in_valid;
   logic          in_ready;
   logic [15:0]   sample;
   logic          sample_stb;
   logic          underrun;
   logic [LW-1:0] fifo_level;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dac_sample_feeder #(
      .CLK_DIV    (CLK_DIV),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .run        (run),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .sample     (sample),
      .sample_stb (sample_stb),
      .underrun   (underrun),
      .fifo_level (fifo_level)
   );

   // Reference model state
   logic [15:0] q [$];
   bit          m_have_lo;
   logic [7:0]  m_lo;
   int          m_cnt;
   logic [15:0] m_sample;
   bit          m_stb;
   bit          m_und;

   logic [15:0] seen [$];
   bit          seen_und [$];
   int          acc;

`ifdef DAC_FEEDER_MUTE_EN
   localparam bit MUTE = 1'b1;
`else
   localparam bit MUTE = 1'b0;
`endif

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] seen_at(input int i);
      if (i < seen.size()) return {16'h0, seen[i]};
      return 32'hFFFF_FFFF;
   endfunction

   function automatic bit m_ready();
      return !m_have_lo || (q.size() < FIFO_DEPTH);
   endfunction

   task automatic model_reset();
      q.delete();
      m_have_lo = 0;
      m_lo      = 8'h00;
      m_cnt     = 0;
      m_sample  = 16'h8080;
      m_stb     = 0;
      m_und     = 0;
   endtask

   task automatic model_step(input logic v, input logic [7:0] d,
                             input logic r, input logic x);
      bit rdy;
      bit bnd;
      if (x) begin
         model_reset();
         return;
      end
      rdy   = m_ready();
      bnd   = r && (m_cnt == CLK_DIV - 1);
      m_stb = bnd;
      m_und = bnd && (q.size() == 0);
      if (bnd) begin
         if (q.size() > 0) m_sample = q.pop_front();
         else if (MUTE) m_sample = 16'h8080;
      end
      if (v && rdy) begin
         if (!m_have_lo) begin
            m_lo      = d;
            m_have_lo = 1;
         end else begin
            q.push_back({d, m_lo});
            m_have_lo = 0;
         end
      end
      m_cnt = r ? (m_cnt + 1) % CLK_DIV : 0;
   endtask

   task automatic tick(input logic v, input logic [7:0] d,
                       input logic r, input logic x = 1'b0);
      @(negedge clk);
      in_valid = v;
      in_data  = d;
      run      = r;
      rst      = x;
      chk("sample", {16'h0, sample}, {16'h0, m_sample});
      chk("stb", {31'h0, sample_stb}, {31'h0, m_stb});
      chk("underrun", {31'h0, underrun}, {31'h0, m_und});
      chk("level", 32'(fifo_level), 32'(q.size()));
      chk("ready", {31'h0, in_ready}, {31'h0, m_ready()});
      if (sample_stb) begin
         seen.push_back(sample);
         seen_und.push_back(underrun);
      end
      if (v && in_ready && !x) acc++;
      @(posedge clk);
      model_step(v, d, r, x);
   endtask

   initial begin
      int pct;
      rst      = 1'b1;
      run      = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (2) @(posedge clk);
      model_reset();

      // Idle after reset: midscale with underrun every period
      tick(0, 8'h00, 1'b0);
      chk("rst_sample", {16'h0, sample}, 32'h8080);
      repeat (9) tick(0, 8'h00, 1'b1);

      // Two frames in order
      tick(0, 8'h00, 1'b0, 1'b1);
      tick(1, 8'h12, 1'b0);
      tick(1, 8'h34, 1'b0);
      tick(1, 8'h56, 1'b0);
      tick(1, 8'h78, 1'b0);
      seen.delete();
      repeat (10) tick(0, 8'h00, 1'b1);
      chk("pair0", seen_at(0), 32'h3412);
      chk("pair1", seen_at(1), 32'h7856);

      // Fill to full with in_valid held, then drain
      tick(0, 8'h00, 1'b0, 1'b1);
      acc = 0;
      repeat (12) tick(1, 8'(acc), 1'b0);
      #1;
      chk("full_acc", 32'(acc), 32'd9);
      chk("full_lvl", 32'(fifo_level), 32'd4);
      chk("full_rdy", {31'h0, in_ready}, 32'd0);
      seen.delete();
      repeat (20) tick(0, 8'h00, 1'b1);
      chk("drain0", seen_at(0), 32'h0100);
      chk("drain1", seen_at(1), 32'h0302);
      chk("drain2", seen_at(2), 32'h0504);
      chk("drain3", seen_at(3), 32'h0706);

      // Underrun after a single frame
      tick(0, 8'h00, 1'b0, 1'b1);
      tick(1, 8'hC3, 1'b0);
      tick(1, 8'hA5, 1'b0);
      seen.delete();
      seen_und.delete();
      repeat (10) tick(0, 8'h00, 1'b1);
      chk("ur_frame", seen_at(0), 32'hA5C3);
      chk("ur_next", seen_at(1), MUTE ? 32'h8080 : 32'hA5C3);
      chk("ur_flag", seen_und.size() > 1 ? 32'(seen_und[1]) : 32'hF, 32'd1);

      // Push landing on the boundary cycle with one frame stored
      tick(0, 8'h00, 1'b0, 1'b1);
      tick(1, 8'h11, 1'b0);
      tick(1, 8'h11, 1'b0);
      tick(1, 8'h22, 1'b0);
      seen.delete();
      repeat (3) tick(0, 8'h00, 1'b1);
      tick(1, 8'h33, 1'b1);
      #1;
      chk("bnd_lvl", 32'(fifo_level), 32'd1);
      repeat (8) tick(0, 8'h00, 1'b1);
      chk("bnd0", seen_at(0), 32'h1111);
      chk("bnd1", seen_at(1), 32'h3322);

      // Reset mid-frame discards held byte and stored frames
      tick(0, 8'h00, 1'b0, 1'b1);
      tick(1, 8'hA1, 1'b0);
      tick(1, 8'hA2, 1'b0);
      tick(1, 8'hB1, 1'b0);
      tick(1, 8'hB2, 1'b0);
      tick(1, 8'hEE, 1'b0);
      #1;
      chk("mid_lvl2", 32'(fifo_level), 32'd2);
      tick(0, 8'h00, 1'b0, 1'b1);
      #1;
      chk("mid_lvl0", 32'(fifo_level), 32'd0);
      chk("mid_smp", {16'h0, sample}, 32'h8080);
      tick(1, 8'h01, 1'b0);
      tick(1, 8'h02, 1'b0);
      seen.delete();
      repeat (6) tick(0, 8'h00, 1'b1);
      chk("mid_frame", seen_at(0), 32'h0201);

      // Randomized traffic with varying input rate, pauses and resets
      pct = 50;
      for (int i = 0; i < 1500; i++) begin
         if (i % 200 == 0) pct = $urandom_range(10, 95);
         tick(($urandom_range(0, 99) < pct),
              8'($urandom),
              ($urandom_range(0, 9) != 0),
              ($urandom_range(0, 199) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
